// File: rtl/regfile_write_arbiter_if.sv
// Write-port sharing bus: requester A (writeback), requester B (multi-cycle
// unit) and the registered register-file write port they share.
//
// Handshake: a requester raises valid with stable addr/data and holds all
// three until ready; a beat transfers on the rising clk edge where valid and
// ready are both 1. ready is combinational and at most one ready is high.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              b_valid;
  logic              b_ready;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ctrl;
  logic              grant_src;
  logic              force_b;
  logic              zero_drop;
  // Aging state, visible for checkers
  logic [3:0]        dbg_wait_cnt;
  logic              dbg_mode;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, wr_addr, wr_data, wr_ctrl, grant_src,
           force_b, zero_drop, dbg_wait_cnt, dbg_mode
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, wr_addr, wr_data, wr_ctrl, grant_src,
           force_b, zero_drop, dbg_wait_cnt, dbg_mode
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between the writeback stage (A)
// and the multi-cycle unit (B). A has fixed priority; an aging counter forces
// B through after MAX_WAIT consecutive refused cycles. The write port is
// registered (one cycle latency) and writes to r0 are dropped with a pulse.
module regfile_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  regfile_write_arbiter_if.slave bus
);

  localparam logic [3:0] MAX_W4 = 4'(MAX_WAIT);

  typedef enum logic {
    MODE_NORMAL = 1'b0,
    MODE_FORCE  = 1'b1
  } mode_t;

  mode_t             mode;
  logic [3:0]        wait_cnt;
  logic [3:0]        wait_nxt;
  logic              force_b;
  logic              a_ready;
  logic              b_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ctrl;
  logic              grant_src;
  logic              zero_drop;

  // Arbitration: A wins unless B has aged into FORCE mode
  always_comb begin
    force_b = (mode == MODE_FORCE) && bus.b_valid;
    a_ready = bus.a_valid && !force_b;
    b_ready = bus.b_valid && (!bus.a_valid || force_b);
  end

  // Next aging count: grows while B is refused, clears once B is served or idle
  always_comb begin
    wait_nxt = '0;
    if (bus.b_valid && !b_ready) begin
      wait_nxt = (wait_cnt == MAX_W4) ? wait_cnt : wait_cnt + 4'd1;
    end
  end

  // Aging FSM and registered write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode      <= MODE_NORMAL;
      wait_cnt  <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_ctrl   <= 1'b0;
      grant_src <= 1'b0;
      zero_drop <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      mode     <= (wait_nxt == MAX_W4) ? MODE_FORCE : MODE_NORMAL;
      if (a_ready) begin
        wr_addr   <= bus.a_addr;
        wr_data   <= bus.a_data;
        grant_src <= 1'b0;
        wr_ctrl   <= (bus.a_addr != '0);
        zero_drop <= (bus.a_addr == '0);
      end else if (b_ready) begin
        wr_addr   <= bus.b_addr;
        wr_data   <= bus.b_data;
        grant_src <= 1'b1;
        wr_ctrl   <= (bus.b_addr != '0);
        zero_drop <= (bus.b_addr == '0);
      end else begin
        // No beat: write strobe and drop pulse fall, payload holds
        wr_ctrl   <= 1'b0;
        zero_drop <= 1'b0;
      end
    end
  end

  assign bus.a_ready      = a_ready;
  assign bus.b_ready      = b_ready;
  assign bus.force_b      = force_b;
  assign bus.wr_addr      = wr_addr;
  assign bus.wr_data      = wr_data;
  assign bus.wr_ctrl      = wr_ctrl;
  assign bus.grant_src    = grant_src;
  assign bus.zero_drop    = zero_drop;
  assign bus.dbg_wait_cnt = wait_cnt;
  assign bus.dbg_mode     = mode;

endmodule
